// File: rtl/vic_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vic_arbiter_if
//  Description : CPU-side vector-fetch handshake bundle (virq/istb/ivec/iack).
//  Revision    : 1.0  initial release
// ============================================================================
interface vic_arbiter_if;
    logic        virq;
    logic        istb;
    logic [15:0] ivec;
    logic        iack;

    // CPU side: raises istb, consumes the vector
    modport master (
        output istb,
        input  virq,
        input  ivec,
        input  iack
    );

    // Interrupt controller side
    modport slave (
        input  istb,
        output virq,
        output ivec,
        output iack
    );
endinterface
`default_nettype wire

// File: rtl/vic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vic_arbiter
//  Description : Fixed-priority vectored interrupt controller with edge-latched
//                requests and an istb/iack vector-fetch handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module vic_arbiter #(
    parameter int                 NREQ      = 4,
    parameter logic [NREQ*16-1:0] VECTORS   = {16'o300, 16'o100, 16'o064, 16'o060},
    parameter logic [15:0]        STRAY_VEC = 16'o000
) (
    input  wire logic            clk_p,
    input  wire logic            rst_n,
    input  wire logic [NREQ-1:0] irq_i,
    input  wire logic [NREQ-1:0] ien_i,
    output logic      [NREQ-1:0] irq_ack_o,
    output logic      [NREQ-1:0] pend_o,
    vic_arbiter_if.slave         cpu
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] irq_q;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [NREQ-1:0] ack_q,  ack_d;
    logic            virq_q, virq_d;
    logic            iack_q, iack_d;
    logic [15:0]     ivec_q, ivec_d;

    logic [NREQ-1:0] w_rise;
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_win_oh;
    logic [15:0]     w_win_vec;

    assign w_rise = irq_i & ~irq_q;
    assign w_elig = pend_q & ien_i;

    // Descending scan so the lowest eligible index is the last one written
    always_comb begin
        w_win_oh  = '0;
        w_win_vec = STRAY_VEC;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
                w_win_vec   = VECTORS[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | w_rise;
        ack_d   = '0;
        virq_d  = 1'b0;
        iack_d  = iack_q;
        ivec_d  = ivec_q;
        unique case (state_q)
            S_IDLE: begin
                virq_d = |w_elig;
                if (cpu.istb) begin
                    state_d = S_GRANT;
                    virq_d  = 1'b0;
                    iack_d  = 1'b1;
                    if (|w_elig) begin
                        ivec_d = w_win_vec;
                        ack_d  = w_win_oh;
                        // Clear beats a coincident new edge on the winner
                        pend_d = (pend_q | w_rise) & ~w_win_oh;
                    end else begin
                        ivec_d = STRAY_VEC;
                    end
                end
            end
            S_GRANT: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!cpu.istb) begin
                    state_d = S_IDLE;
                    iack_d  = 1'b0;
                    ivec_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                iack_d  = 1'b0;
                ivec_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            irq_q   <= '0;
            pend_q  <= '0;
            ack_q   <= '0;
            virq_q  <= 1'b0;
            iack_q  <= 1'b0;
            ivec_q  <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_i;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            virq_q  <= virq_d;
            iack_q  <= iack_d;
            ivec_q  <= ivec_d;
        end
    end

    assign irq_ack_o = ack_q;
    assign pend_o    = pend_q;
    assign cpu.virq  = virq_q;
    assign cpu.iack  = iack_q;
    assign cpu.ivec  = ivec_q;

endmodule
`default_nettype wire

// File: tb/tb_vic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vic_arbiter
//  Description : Self-checking bench for vic_arbiter: directed scenarios plus
//                randomized pulses/masks against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vic_arbiter;

    localparam int NREQ = 4;

    logic            clk_p = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] irq_i;
    logic [NREQ-1:0] ien_i;
    logic [NREQ-1:0] irq_ack_o;
    logic [NREQ-1:0] pend_o;

    vic_arbiter_if cpu ();

    vic_arbiter #(.NREQ(NREQ)) dut (
        .clk_p     (clk_p),
        .rst_n     (rst_n),
        .irq_i     (irq_i),
        .ien_i     (ien_i),
        .irq_ack_o (irq_ack_o),
        .pend_o    (pend_o),
        .cpu       (cpu)
    );

    always #5 clk_p = ~clk_p;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] vec_tab [NREQ] = '{16'o060, 16'o064, 16'o100, 16'o300};

    // Values captured across one full fetch handshake
    logic [15:0]     f_v1, f_v3;
    logic            f_ia1, f_ia2, f_ia3, f_vq1;
    logic [NREQ-1:0] f_ack1, f_ack2, f_pend1;

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic do_fetch();
        cpu.istb = 1'b1;
        tick();
        f_v1 = cpu.ivec; f_ia1 = cpu.iack; f_ack1 = irq_ack_o;
        f_pend1 = pend_o; f_vq1 = cpu.virq;
        tick();
        f_ack2 = irq_ack_o; f_ia2 = cpu.iack;
        cpu.istb = 1'b0;
        tick();
        f_ia3 = cpu.iack; f_v3 = cpu.ivec;
    endtask

    task automatic pulse(input logic [NREQ-1:0] m);
        irq_i = m;
        tick();
        irq_i = '0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq_i = '0; ien_i = '0; cpu.istb = 1'b0;
        #12;
        n_tests++;
        if ({cpu.virq, cpu.iack, cpu.ivec, irq_ack_o, pend_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got virq=%b iack=%b ivec=%o ack=%b pend=%b expected all zero",
                     cpu.virq, cpu.iack, cpu.ivec, irq_ack_o, pend_o);
        end
        @(negedge clk_p);
        rst_n = 1'b1;
        ien_i = 4'hF;
        tick(); tick();
    endtask

    task automatic test_single();
        irq_i = 4'b0100;
        tick();
        n_tests++;
        if (pend_o !== 4'b0100 || cpu.virq !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pend got pend=%b virq=%b expected pend=0100 virq=0", pend_o, cpu.virq);
        end
        irq_i = '0;
        tick();
        n_tests++;
        if (cpu.virq !== 1'b1) begin
            n_fail++;
            $display("FAIL single_virq got %b expected 1", cpu.virq);
        end
        do_fetch();
        n_tests++;
        if (f_v1 !== 16'o100 || f_ia1 !== 1'b1 || f_ack1 !== 4'b0100 || f_pend1 !== 4'b0000 || f_vq1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant got ivec=%o iack=%b ack=%b pend=%b virq=%b expected 100 1 0100 0000 0",
                     f_v1, f_ia1, f_ack1, f_pend1, f_vq1);
        end
        n_tests++;
        if (f_ack2 !== 4'b0000 || f_ia2 !== 1'b1 || f_ia3 !== 1'b0 || f_v3 !== 16'o0) begin
            n_fail++;
            $display("FAIL single_release got ack2=%b iack2=%b iack3=%b ivec3=%o expected 0000 1 0 0",
                     f_ack2, f_ia2, f_ia3, f_v3);
        end
    endtask

    task automatic test_simultaneous();
        pulse(4'b1010);
        do_fetch();
        n_tests++;
        if (f_v1 !== 16'o064 || f_ack1 !== 4'b0010 || f_pend1 !== 4'b1000) begin
            n_fail++;
            $display("FAIL simul_first got ivec=%o ack=%b pend=%b expected 064 0010 1000", f_v1, f_ack1, f_pend1);
        end
        tick();
        n_tests++;
        if (cpu.virq !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_virq_reassert got %b expected 1", cpu.virq);
        end
        do_fetch();
        n_tests++;
        if (f_v1 !== 16'o300 || f_ack1 !== 4'b1000 || f_pend1 !== 4'b0000) begin
            n_fail++;
            $display("FAIL simul_second got ivec=%o ack=%b pend=%b expected 300 1000 0000", f_v1, f_ack1, f_pend1);
        end
    endtask

    task automatic test_mask();
        ien_i = 4'b1110;
        pulse(4'b0001);
        tick();
        n_tests++;
        if (cpu.virq !== 1'b0 || pend_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL mask_hold got virq=%b pend=%b expected 0 0001", cpu.virq, pend_o);
        end
        ien_i = 4'hF;
        tick();
        n_tests++;
        if (cpu.virq !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_unmask_virq got %b expected 1", cpu.virq);
        end
        do_fetch();
        n_tests++;
        if (f_v1 !== 16'o060 || f_ack1 !== 4'b0001) begin
            n_fail++;
            $display("FAIL mask_fetch got ivec=%o ack=%b expected 060 0001", f_v1, f_ack1);
        end
    endtask

    task automatic test_stray();
        pulse(4'b1000);
        ien_i = 4'b0111;
        do_fetch();
        n_tests++;
        if (f_v1 !== 16'o000 || f_ia1 !== 1'b1 || f_ack1 !== 4'b0000 || f_pend1 !== 4'b1000) begin
            n_fail++;
            $display("FAIL stray_vector got ivec=%o iack=%b ack=%b pend=%b expected 000 1 0000 1000",
                     f_v1, f_ia1, f_ack1, f_pend1);
        end
        ien_i = 4'hF;
        tick();
        n_tests++;
        if (cpu.virq !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_virq_after got %b expected 1", cpu.virq);
        end
        do_fetch();
        n_tests++;
        if (f_v1 !== 16'o300 || f_ack1 !== 4'b1000) begin
            n_fail++;
            $display("FAIL stray_cleanup got ivec=%o ack=%b expected 300 1000", f_v1, f_ack1);
        end
    endtask

    task automatic test_held();
        irq_i = 4'b0010;
        tick(); tick();
        do_fetch();
        n_tests++;
        if (f_v1 !== 16'o064 || f_ack1 !== 4'b0010) begin
            n_fail++;
            $display("FAIL held_first got ivec=%o ack=%b expected 064 0010", f_v1, f_ack1);
        end
        for (int k = 0; k < 2; k++) begin
            do_fetch();
            n_tests++;
            if (f_v1 !== 16'o000 || f_ack1 !== 4'b0000 || f_pend1 !== 4'b0000) begin
                n_fail++;
                $display("FAIL held_repeat%0d got ivec=%o ack=%b pend=%b expected 000 0000 0000",
                         k, f_v1, f_ack1, f_pend1);
            end
        end
        irq_i = 4'b0000; tick();
        irq_i = 4'b0010; tick(); tick();
        n_tests++;
        if (pend_o !== 4'b0010 || cpu.virq !== 1'b1) begin
            n_fail++;
            $display("FAIL held_retoggle got pend=%b virq=%b expected 0010 1", pend_o, cpu.virq);
        end
        do_fetch();
        irq_i = '0;
        tick();
    endtask

    task automatic test_async_reset();
        pulse(4'b1011);
        cpu.istb = 1'b1;
        tick();
        n_tests++;
        if (cpu.iack !== 1'b1 || pend_o !== 4'b1010) begin
            n_fail++;
            $display("FAIL areset_setup got iack=%b pend=%b expected 1 1010", cpu.iack, pend_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (cpu.iack !== 1'b0 || cpu.virq !== 1'b0 || cpu.ivec !== 16'o0 || pend_o !== 4'b0000 || irq_ack_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL areset_clear got iack=%b virq=%b ivec=%o pend=%b ack=%b expected all zero",
                     cpu.iack, cpu.virq, cpu.ivec, pend_o, irq_ack_o);
        end
        cpu.istb = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] m_pend;
        logic [NREQ-1:0] r, en, elig, exp_ack;
        logic [15:0]     exp_vec;
        logic            found;
        rst_n = 1'b0; #3; rst_n = 1'b1;
        tick();
        m_pend = '0;
        for (int it = 0; it < 40; it++) begin
            r  = NREQ'($urandom_range(0, 15));
            en = NREQ'($urandom_range(0, 15));
            ien_i = en;
            pulse(r);
            tick();
            m_pend = m_pend | r;
            n_tests++;
            if (pend_o !== m_pend || cpu.virq !== |(m_pend & en)) begin
                n_fail++;
                $display("FAIL rand%0d_status got pend=%b virq=%b expected pend=%b virq=%b",
                         it, pend_o, cpu.virq, m_pend, |(m_pend & en));
            end
            if ($urandom_range(0, 3) != 0) begin
                elig = m_pend & en;
                exp_vec = 16'o000;
                exp_ack = '0;
                found = 1'b0;
                for (int s = 0; s < NREQ; s++) begin
                    if (!found && elig[s]) begin
                        found = 1'b1;
                        exp_vec = vec_tab[s];
                        exp_ack[s] = 1'b1;
                    end
                end
                m_pend = m_pend & ~exp_ack;
                do_fetch();
                n_tests++;
                if (f_v1 !== exp_vec || f_ack1 !== exp_ack || f_ia1 !== 1'b1 || f_pend1 !== m_pend
                    || f_ack2 !== '0 || f_ia3 !== 1'b0 || f_v3 !== 16'o0) begin
                    n_fail++;
                    $display("FAIL rand%0d_fetch got ivec=%o ack=%b iack=%b pend=%b ack2=%b iack3=%b expected ivec=%o ack=%b iack=1 pend=%b ack2=0 iack3=0",
                             it, f_v1, f_ack1, f_ia1, f_pend1, f_ack2, f_ia3, exp_vec, exp_ack, m_pend);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_mask();
        test_stray();
        test_held();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
